snn_timestep_scheduler: RTL and testbench

//  Time-multiplexed synapse scheduler for the SNN core. On each timestep tick (the 20 kHz enable) it

---
 rtl/snn_pkg.sv | 32 +++
 rtl/snn_timestep_scheduler_if.sv | 30 +++
 rtl/snn_sat_acc.sv | 36 +++
 rtl/snn_timestep_scheduler.sv | 157 +++++++++++++++
 tb/tb_snn_timestep_scheduler.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// Shared types and arithmetic for the SNN timestep scheduler.
// Holds the FSM state enum, default widths and the saturating add helper.
package snn_pkg;

    localparam int DW_DEF    = 16;
    localparam int WW_DEF    = 24;
    localparam int SHIFT_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ACC,
        ST_EMIT,
        ST_DONE
    } sched_state_t;

    // Adds at full width, then clamps to the signed range of a dw-bit word.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int dw);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/snn_timestep_scheduler_if.sv
// Weight-ROM read port and summed-current valid/ready port of the scheduler.
// master = scheduler side, slave = ROM / neuron-update consumer side.
interface snn_timestep_scheduler_if import snn_pkg::*; #(
    parameter int DW       = DW_DEF,
    parameter int WW       = WW_DEF,
    parameter int INPUTNUM = 4,
    parameter int EXCNUM   = 2
);
    localparam int AW = (INPUTNUM * EXCNUM > 1) ? $clog2(INPUTNUM * EXCNUM) : 1;
    localparam int IW = (EXCNUM > 1) ? $clog2(EXCNUM) : 1;

    logic [AW-1:0]        w_addr;
    logic                 w_rd;
    logic signed [WW-1:0] w_data;
    logic signed [DW-1:0] sum_data;
    logic [IW-1:0]        sum_idx;
    logic                 sum_valid;
    logic                 sum_ready;

    modport master (
        output w_addr, w_rd, sum_data, sum_idx, sum_valid,
        input  w_data, sum_ready
    );

    modport slave (
        input  w_addr, w_rd, sum_data, sum_idx, sum_valid,
        output w_data, sum_ready
    );

endinterface

// File: rtl/snn_sat_acc.sv
// Clear/add-enable saturating accumulator: sums a signed term into a DW-bit
// register, clamping to the DW signed range on every add.
module snn_sat_acc import snn_pkg::*; #(
    parameter int DW = DW_DEF,
    parameter int TW = WW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 add,
    input  logic signed [TW-1:0] term,
    output logic signed [DW-1:0] acc
);

    logic signed [63:0] acc_wide;
    logic signed [63:0] term_wide;
    logic signed [63:0] sum_wide;
    logic               unused_hi;

    assign acc_wide  = {{(64 - DW){acc[DW-1]}}, acc};
    assign term_wide = {{(64 - TW){term[TW-1]}}, term};
    assign sum_wide  = sat_add(acc_wide, term_wide, DW);
    // Upper bits are only sign copies after the clamp.
    assign unused_hi = ^sum_wide[63:DW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (add) begin
            acc <= sum_wide[DW-1:0];
        end
    end

endmodule

// File: rtl/snn_timestep_scheduler.sv
// Time-multiplexed synapse scheduler: per tick, walks INPUTNUM x EXCNUM synapses
// through one saturating accumulator. Optional build macro: SNN_SCHED_ZERO_SKIP_EN.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  ST_IDLE  | waiting for tick & en; snapshot spikes, clear acc
//  ST_FETCH | drive weight read for synapse (j,i)
//  ST_ACC   | add shifted weight if input i spiked; advance i
//  ST_EMIT  | present neuron j's sum; wait for sum_ready
//  ST_DONE  | one-cycle neuron-update strobe
module snn_timestep_scheduler import snn_pkg::*; #(
    parameter int DW       = DW_DEF,
    parameter int WW       = WW_DEF,
    parameter int INPUTNUM = 4,
    parameter int EXCNUM   = 2,
    parameter int SHIFT    = SHIFT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                tick,
    input  logic [INPUTNUM-1:0] pre_spike,
    snn_timestep_scheduler_if.master bus,
    output logic                upd_strobe,
    output logic                busy,
    output logic                overrun
);

    localparam int AW  = (INPUTNUM * EXCNUM > 1) ? $clog2(INPUTNUM * EXCNUM) : 1;
    localparam int IBW = (INPUTNUM > 1) ? $clog2(INPUTNUM) : 1;
    localparam int JBW = (EXCNUM > 1) ? $clog2(EXCNUM) : 1;

    sched_state_t         state_q, state_d;
    logic [IBW-1:0]       i_q, i_d;
    logic [JBW-1:0]       j_q, j_d;
    logic [INPUTNUM-1:0]  snap_q, snap_d;
    logic                 overrun_q;
    logic                 acc_clr;
    logic                 acc_add;
    logic                 last_i;
    logic                 last_j;
    logic signed [WW-1:0] term;
    logic signed [DW-1:0] acc;

    assign last_i = (i_q == IBW'(INPUTNUM - 1));
    assign last_j = (j_q == JBW'(EXCNUM - 1));
    assign term   = bus.w_data >>> SHIFT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            snap_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            snap_q  <= snap_d;
            if (en && tick && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        snap_d  = snap_q;
        acc_clr = 1'b0;
        acc_add = 1'b0;
        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        snap_d  = pre_spike;
                        acc_clr = 1'b1;
                        i_d     = '0;
                        j_d     = '0;
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
`ifdef SNN_SCHED_ZERO_SKIP_EN
                    // Silent inputs cost one scan cycle and no ROM access.
                    if (!snap_q[i_q]) begin
                        if (last_i) begin
                            state_d = ST_EMIT;
                        end else begin
                            i_d = i_q + 1'b1;
                        end
                    end else begin
                        state_d = ST_ACC;
                    end
`else
                    state_d = ST_ACC;
`endif
                end
                ST_ACC: begin
                    acc_add = snap_q[i_q];
                    if (last_i) begin
                        state_d = ST_EMIT;
                    end else begin
                        i_d     = i_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
                ST_EMIT: begin
                    if (bus.sum_ready) begin
                        if (last_j) begin
                            state_d = ST_DONE;
                        end else begin
                            j_d     = j_q + 1'b1;
                            i_d     = '0;
                            acc_clr = 1'b1;
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    snn_sat_acc #(
        .DW (DW),
        .TW (WW)
    ) u_acc (
        .clk   (clk),
        .rst_n (rst),
        .clr   (acc_clr),
        .add   (acc_add),
        .term  (term),
        .acc   (acc)
    );

`ifdef SNN_SCHED_ZERO_SKIP_EN
    assign bus.w_rd = (state_q == ST_FETCH) && snap_q[i_q];
`else
    assign bus.w_rd = (state_q == ST_FETCH);
`endif
    assign bus.w_addr    = AW'(int'(j_q) * INPUTNUM + int'(i_q));
    assign bus.sum_valid = (state_q == ST_EMIT);
    assign bus.sum_data  = acc;
    assign bus.sum_idx   = j_q;
    assign upd_strobe    = (state_q == ST_DONE);
    assign busy          = (state_q != ST_IDLE);
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Self-checking bench for snn_timestep_scheduler with a behavioural weight ROM
// and an arithmetic reference model of the per-neuron summed current.
module tb_snn_timestep_scheduler;

    localparam int DW    = 16;
    localparam int WW    = 24;
    localparam int NI    = 4;
    localparam int NE    = 2;
    localparam int SHIFT = 8;

    logic          clk;
    logic          rst;
    logic          en;
    logic          tick;
    logic [NI-1:0] pre_spike;
    logic          upd_strobe;
    logic          busy;
    logic          overrun;

    logic signed [WW-1:0] rom [NI*NE];

    int n_assert = 0;
    int n_fail   = 0;

    snn_timestep_scheduler_if #(.DW(DW), .WW(WW), .INPUTNUM(NI), .EXCNUM(NE)) bus ();

    snn_timestep_scheduler #(
        .DW(DW), .WW(WW), .INPUTNUM(NI), .EXCNUM(NE), .SHIFT(SHIFT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .tick       (tick),
        .pre_spike  (pre_spike),
        .bus        (bus),
        .upd_strobe (upd_strobe),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight ROM: one-cycle read latency, output held while w_rd is low.
    always @(posedge clk) begin
        if (bus.w_rd) bus.w_data <= rom[bus.w_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sum of floor(w / 2^SHIFT) over spiking inputs, clamped after every term.
    function automatic longint model_sum(input int j, input logic [NI-1:0] spk);
        longint acc, lim_hi, lim_lo, div;
        int w, t;
        acc    = 0;
        lim_hi = (longint'(1) << (DW - 1)) - 1;
        lim_lo = -(longint'(1) << (DW - 1));
        div    = longint'(1) << SHIFT;
        for (int i = 0; i < NI; i++) begin
            if (spk[i]) begin
                w = rom[j * NI + i];
                t = (w >= 0) ? int'(w / div) : -int'((-w + div - 1) / div);
                acc = acc + t;
                if (acc > lim_hi) acc = lim_hi;
                if (acc < lim_lo) acc = lim_lo;
            end
        end
        return acc;
    endfunction

    // Cycles spent scanning the inputs of one neuron before its sum is presented.
    function automatic int scan_cost(input logic [NI-1:0] spk);
        int c;
        c = 0;
        for (int i = 0; i < NI; i++) begin
`ifdef SNN_SCHED_ZERO_SKIP_EN
            c += spk[i] ? 2 : 1;
`else
            c += 2;
`endif
        end
        return c;
    endfunction

    task automatic pulse_tick(input logic [NI-1:0] spk);
        pre_spike = spk;
        tick = 1'b1;
        step();
        tick = 1'b0;
        pre_spike = NI'($urandom);
    endtask

    // Collect all handshaken sums until upd_strobe; cycle 1 = first cycle after the tick edge.
    task automatic drain(input logic [NI-1:0] spk, input bit chk_lat, input string tag);
        int cyc, got;
        bit done;
        cyc = 1; got = 0; done = 0;
        while (!done && cyc < 400) begin
            if (bus.sum_valid && bus.sum_ready) begin
                chk({tag, "_idx"}, bus.sum_idx, got);
                chk({tag, "_sum"}, bus.sum_data, model_sum(got, spk));
                if (chk_lat && got == 0) chk({tag, "_lat_valid"}, cyc, scan_cost(spk) + 1);
                got++;
            end
            if (upd_strobe) begin
                done = 1;
                chk({tag, "_nsums"}, got, NE);
                chk({tag, "_busy_done"}, busy, 1);
                if (chk_lat) chk({tag, "_lat_upd"}, cyc, NE * (scan_cost(spk) + 1) + 1);
            end
            step();
            cyc++;
        end
        chk({tag, "_timeout"}, done, 1);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_strobe_1cyc"}, upd_strobe, 0);
    endtask

    task automatic rand_rom();
        for (int k = 0; k < NI * NE; k++) rom[k] = WW'($urandom);
    endtask

    initial begin
        logic [NI-1:0]        spk;
        logic signed [DW-1:0] d0;
        logic [0:0]           i0;
        logic [2:0]           a0;
        int                   cnt;

        rst = 1'b0; en = 1'b1; tick = 1'b0; pre_spike = '0;
        bus.sum_ready = 1'b1;
        rand_rom();
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_valid", bus.sum_valid, 0);
        chk("rst_data", bus.sum_data, 0);
        chk("rst_idx", bus.sum_idx, 0);
        chk("rst_upd", upd_strobe, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_wrd", bus.w_rd, 0);
        chk("rst_waddr", bus.w_addr, 0);
        rst = 1'b1;
        step();

        // Tick while disabled in IDLE is dropped without overrun.
        en = 1'b0;
        pulse_tick(4'b1111);
        en = 1'b1;
        chk("en0_busy", busy, 0);
        step();
        chk("en0_busy2", busy, 0);
        chk("en0_overrun", overrun, 0);

        pulse_tick(4'b1111);
        drain(4'b1111, 1, "all");

        rand_rom();
        pulse_tick(4'b0110);
        drain(4'b0110, 1, "p0110");

        for (int r = 0; r < 4; r++) begin
            rand_rom();
            spk = NI'($urandom);
            pulse_tick(spk);
            drain(spk, 1, "rand");
        end

        rand_rom();
        pulse_tick(4'b0000);
        drain(4'b0000, 1, "zero");

        for (int k = 0; k < NI * NE; k++) rom[k] = 24'h7FFFFF;
        pulse_tick(4'b1111);
        drain(4'b1111, 1, "satp");
        chk("satp_model", model_sum(1, 4'b1111), 32767);

        for (int k = 0; k < NI * NE; k++) rom[k] = 24'h800000;
        pulse_tick(4'b1111);
        drain(4'b1111, 1, "satn");
        chk("satn_model", model_sum(0, 4'b1111), -32768);

        // Clamp, then a negative term applies to the clamped value.
        rom[0] = 24'h7FFFFF; rom[1] = 24'h7FFFFF; rom[2] = 24'h800000; rom[3] = 24'h000000;
        rom[4] = 24'h800000; rom[5] = 24'h800000; rom[6] = 24'h7FFFFF; rom[7] = 24'hFFFFFF;
        pulse_tick(4'b1111);
        drain(4'b1111, 1, "satmix");
        chk("satmix_model0", model_sum(0, 4'b1111), -1);
        chk("satmix_model1", model_sum(1, 4'b1111), -2);

        // en low mid-operation freezes everything.
        rand_rom();
        spk = 4'b1011;
        pulse_tick(spk);
        repeat (2) step();
        a0 = bus.w_addr;
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("frz_busy", busy, 1);
            chk("frz_addr", bus.w_addr, a0);
        end
        en = 1'b1;
        drain(spk, 0, "frz");

        // Tick in the DONE cycle is ignored but flagged.
        chk("done_ovr_pre", overrun, 0);
        spk = 4'b1101;
        pulse_tick(spk);
        cnt = 0;
        while (!upd_strobe && cnt < 100) begin step(); cnt++; end
        chk("done_reach", upd_strobe, 1);
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("done_tick_busy", busy, 0);
        chk("done_tick_ovr", overrun, 1);
        step();
        chk("done_tick_nostart", busy, 0);

        // Reset during ACC of neuron 1.
        rand_rom();
        pulse_tick(4'b1111);
        cnt = 0;
        while (!(busy && bus.sum_idx == 1 && !bus.w_rd && !bus.sum_valid) && cnt < 100) begin
            step(); cnt++;
        end
        chk("rstmid_reach", bus.sum_idx, 1);
        rst = 1'b0;
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_data", bus.sum_data, 0);
        chk("rstmid_idx", bus.sum_idx, 0);
        chk("rstmid_ovr", overrun, 0);
        chk("rstmid_wrd", bus.w_rd, 0);
        step();
        rst = 1'b1;
        step();
        spk = 4'b0111;
        pulse_tick(spk);
        drain(spk, 1, "rstfresh");

        // Stall at neuron 0 with a tick during the stall.
        rand_rom();
        bus.sum_ready = 1'b0;
        spk = 4'b1110;
        pulse_tick(spk);
        cnt = 0;
        while (!bus.sum_valid && cnt < 100) begin step(); cnt++; end
        chk("stall_reach", bus.sum_valid, 1);
        d0 = bus.sum_data;
        i0 = bus.sum_idx;
        chk("stall_d0", d0, model_sum(0, spk));
        chk("stall_i0", i0, 0);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                tick = 1'b1;
                pre_spike = ~spk;
            end
            step();
            tick = 1'b0;
            chk("stall_valid", bus.sum_valid, 1);
            chk("stall_data", bus.sum_data, d0);
            chk("stall_idx", bus.sum_idx, i0);
        end
        chk("stall_overrun", overrun, 1);
        bus.sum_ready = 1'b1;
        drain(spk, 0, "stall");
        chk("stall_ovr_sticky", overrun, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
